// File: rtl/tetris_pkg.sv
// Shared key indices, command codes and repeat-timer state type for the
// key-to-command path.
package tetris_pkg;

    localparam int NKEY = 5;
    localparam int NREP = 3;

    localparam int KEY_LEFT   = 0;
    localparam int KEY_RIGHT  = 1;
    localparam int KEY_DOWN   = 2;
    localparam int KEY_ROTATE = 3;
    localparam int KEY_DROP   = 4;

    localparam logic [2:0] CMD_NONE   = 3'd0;
    localparam logic [2:0] CMD_LEFT   = 3'd1;
    localparam logic [2:0] CMD_RIGHT  = 3'd2;
    localparam logic [2:0] CMD_DOWN   = 3'd3;
    localparam logic [2:0] CMD_ROTATE = 3'd4;
    localparam logic [2:0] CMD_DROP   = 3'd5;

    typedef enum logic [1:0] {
        RPT_IDLE = 2'd0,
        RPT_DAS  = 2'd1,
        RPT_ARR  = 2'd2
    } rpt_state_e;

endpackage

// File: rtl/key_repeat_timer.sv
// Auto-repeat timer for one held key: a first repeat after DAS_MS ticks,
// then one every ARR_MS ticks until release.
//
// state    | meaning
// RPT_IDLE | key not held, no repeats
// RPT_DAS  | counting the initial delay before the first repeat
// RPT_ARR  | repeating at the fixed rate
module key_repeat_timer
    import tetris_pkg::*;
#(
    parameter int DAS_MS = 170,
    parameter int ARR_MS = 50
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic press_i,
    input  logic release_i,
    input  logic tick_i,
    output logic fire_o
);

    localparam int CNT_MAX = (DAS_MS > ARR_MS) ? DAS_MS : ARR_MS;
    localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CW-1:0] DAS_LAST = CW'(DAS_MS - 1);
    localparam logic [CW-1:0] ARR_LAST = CW'(ARR_MS - 1);

    rpt_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RPT_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        fire_o  = 1'b0;
        if (clr_i || release_i) begin
            state_d = RPT_IDLE;
            cnt_d   = '0;
        end else if (press_i) begin
            // a fresh press always restarts the initial delay
            state_d = RPT_DAS;
            cnt_d   = '0;
        end else if (tick_i) begin
            case (state_q)
                RPT_DAS: begin
                    if (cnt_q == DAS_LAST) begin
                        fire_o  = 1'b1;
                        state_d = RPT_ARR;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                RPT_ARR: begin
                    if (cnt_q == ARR_LAST) begin
                        fire_o = 1'b1;
                        cnt_d  = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/key_cmd_scheduler.sv
// Merges debounced key press/release pulses and auto-repeat events into a
// single priority-ordered command stream on a valid/ready interface.
module key_cmd_scheduler
    import tetris_pkg::*;
#(
    parameter int CLK_DIV = 100_000,
    parameter int DAS_MS  = 170,
    parameter int ARR_MS  = 50
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic [4:0] key_press,
    input  logic [4:0] key_release,
    output logic       cmd_valid,
    output logic [2:0] cmd_code,
    input  logic       cmd_ready
);

    localparam int TW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(CLK_DIV - 1);

    logic [TW-1:0]   tick_cnt_q, tick_cnt_d;
    logic            tick;
    logic [NKEY-1:0] held_q, held_d;
    logic [NKEY-1:0] pending_q, pending_d;
    logic            cmd_valid_q, cmd_valid_d;
    logic [2:0]      cmd_code_q, cmd_code_d;

    logic [NKEY-1:0] press_vld, press_eff, rel_vld, kill, ev;
    logic            lr_clash;
    logic [NREP-1:0] clr_rpt, fire, rpt_ev;
    logic [NKEY-1:0] grant_oh;
    logic [2:0]      grant_code;
    logic            load;

    assign tick       = (tick_cnt_q == TICK_LAST);
    assign tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;

    // release beats a same-cycle press; simultaneous left+right cancel out
    assign press_vld = {NKEY{enable}} & key_press & ~key_release;
    assign lr_clash  = press_vld[KEY_LEFT] & press_vld[KEY_RIGHT];
    assign press_eff = press_vld & ~{3'b000, lr_clash, lr_clash};
    assign rel_vld   = {NKEY{enable}} & key_release;
    assign kill      = {3'b000, press_eff[KEY_LEFT], press_eff[KEY_RIGHT]};

    assign clr_rpt = {NREP{~enable}} | kill[NREP-1:0];

    for (genvar k = 0; k < NREP; k++) begin : g_rpt
        key_repeat_timer #(
            .DAS_MS(DAS_MS),
            .ARR_MS(ARR_MS)
        ) u_rpt (
            .clk      (clk),
            .rst_n    (rst_n),
            .clr_i    (clr_rpt[k]),
            .press_i  (press_eff[k]),
            .release_i(rel_vld[k]),
            .tick_i   (tick),
            .fire_o   (fire[k])
        );
    end

    assign rpt_ev = fire & held_q[NREP-1:0];
    assign ev     = press_eff | {2'b00, rpt_ev};

    always_comb begin
        grant_oh   = '0;
        grant_code = CMD_NONE;
        if (pending_q[KEY_DROP]) begin
            grant_oh[KEY_DROP] = 1'b1;
            grant_code         = CMD_DROP;
        end else if (pending_q[KEY_ROTATE]) begin
            grant_oh[KEY_ROTATE] = 1'b1;
            grant_code           = CMD_ROTATE;
        end else if (pending_q[KEY_DOWN]) begin
            grant_oh[KEY_DOWN] = 1'b1;
            grant_code         = CMD_DOWN;
        end else if (pending_q[KEY_LEFT]) begin
            grant_oh[KEY_LEFT] = 1'b1;
            grant_code         = CMD_LEFT;
        end else if (pending_q[KEY_RIGHT]) begin
            grant_oh[KEY_RIGHT] = 1'b1;
            grant_code          = CMD_RIGHT;
        end
    end

    // while disabled nothing new is issued, but a presented command may still drain
    assign load = enable && (!cmd_valid_q || cmd_ready) && (|pending_q);

    always_comb begin
        held_d      = '0;
        pending_d   = '0;
        cmd_valid_d = cmd_valid_q;
        cmd_code_d  = cmd_code_q;
        if (enable) begin
            held_d    = (held_q | press_eff) & ~rel_vld & ~kill;
            pending_d = (pending_q & ~(load ? grant_oh : '0) & ~kill) | ev;
        end
        if (load) begin
            cmd_valid_d = 1'b1;
            cmd_code_d  = grant_code;
        end else if (cmd_valid_q && cmd_ready) begin
            cmd_valid_d = 1'b0;
            cmd_code_d  = CMD_NONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt_q  <= '0;
            held_q      <= '0;
            pending_q   <= '0;
            cmd_valid_q <= 1'b0;
            cmd_code_q  <= CMD_NONE;
        end else begin
            tick_cnt_q  <= tick_cnt_d;
            held_q      <= held_d;
            pending_q   <= pending_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_code_q  <= cmd_code_d;
        end
    end

    assign cmd_valid = cmd_valid_q;
    assign cmd_code  = cmd_code_q;

endmodule
